// File: rtl/muldiv_seq_if.sv
// Handshake/operand bundle for muldiv_seq.
//   master : drives start, muordi, sgn, opera1, opera2; receives result and status.
//   slave  : the execution unit side.
// WIDTH must match the WIDTH of the muldiv_seq instance it is connected to.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               muordi;
    logic               sgn;
    logic [WIDTH-1:0]   opera1;
    logic [2*WIDTH-1:0] opera2;
    logic [2*WIDTH-1:0] result;
    logic               valid;
    logic               busy;
    logic               dbz;
    logic               ovf;

    modport master (
        output start, muordi, sgn, opera1, opera2,
        input  result, valid, busy, dbz, ovf
    );

    modport slave (
        input  start, muordi, sgn, opera1, opera2,
        output result, valid, busy, dbz, ovf
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential signed/unsigned multiplier-divider.
// One iterative datapath: W shift-add steps for multiply, 2W restoring-
// subtract steps for divide, all on magnitudes; signs are re-applied in FIX.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high, aborts any operation
//   bus    : muldiv_seq_if.slave (start/muordi/sgn/opera1/opera2 in,
//            result/valid/busy/dbz/ovf out)
// All outputs are registered one stage behind the FSM state, so busy rises
// at E0+1 and valid rises at E0+N+2 (E0+2 for divide by zero).
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(2 * W) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;

    logic           mode_div, sgn_q, dbz_pend, qneg, rneg;
    logic [W-1:0]   opa;        // multiplicand (mul) / divisor (div) magnitude
    logic [2*W-1:0] acc;        // {partial product, multiplier} / quotient shift reg
    logic [W-1:0]   rem;        // partial remainder (div only)
    logic [CW-1:0]  cnt, cnt_last;
    logic [2*W-1:0] res_q;
    logic           dbz_q, ovf_q;

    logic accept, div_zero;
    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign div_zero = bus.muordi && (bus.opera1 == '0);
    assign cnt_last = mode_div ? CW'(2 * W - 1) : CW'(W - 1);

    // Operand magnitudes; -2^(n-1) maps onto itself, which is correct unsigned.
    logic [W-1:0]   mag1, mag2lo;
    logic [2*W-1:0] mag2;
    always_comb begin
        mag1   = (bus.sgn && bus.opera1[W-1])   ? ~bus.opera1 + 1'b1         : bus.opera1;
        mag2lo = (bus.sgn && bus.opera2[W-1])   ? ~bus.opera2[W-1:0] + 1'b1  : bus.opera2[W-1:0];
        mag2   = (bus.sgn && bus.opera2[2*W-1]) ? ~bus.opera2 + 1'b1         : bus.opera2;
    end

    // One iteration step for each mode.
    // Divide: rem < divisor always, so the trial fits W+1 bits and the
    // subtraction's top bit is a clean borrow.
    logic [W:0] msum, trial, diff;
    logic       ge;
    always_comb begin
        msum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opa} : '0);
        trial = {rem, acc[2*W-1]};
        diff  = trial - {1'b0, opa};
        ge    = ~diff[W];
    end

    // Sign fix-up. For multiply qneg carries the product sign, so q_s is the
    // signed product directly.
    logic [2*W-1:0] q_s;
    logic [W-1:0]   r_s;
    logic           ovf_c;
    always_comb begin
        q_s   = qneg ? ~acc + 1'b1 : acc;
        r_s   = rneg ? ~rem + 1'b1 : rem;
        // signed: bits [2W-1:W-1] must be a pure sign extension
        ovf_c = sgn_q ? ~((&q_s[2*W-1:W-1]) | ~(|q_s[2*W-1:W-1]))
                      : (|q_s[2*W-1:W]);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nx = div_zero ? FIX : CALC;
            CALC:       if (cnt == cnt_last) state_nx = FIX;
            FIX:        state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_div <= 1'b0;
            sgn_q    <= 1'b0;
            dbz_pend <= 1'b0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            opa      <= '0;
            acc      <= '0;
            rem      <= '0;
            cnt      <= '0;
            res_q    <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (accept) begin
                    mode_div <= bus.muordi;
                    sgn_q    <= bus.sgn;
                    dbz_pend <= div_zero;
                    cnt      <= '0;
                    rem      <= '0;
                    res_q    <= '0;
                    dbz_q    <= 1'b0;
                    ovf_q    <= 1'b0;
                    if (bus.muordi) begin
                        opa  <= mag1;
                        // divide by zero carries its final result through acc
                        acc  <= div_zero ? {bus.opera2[W-1:0], {W{1'b1}}} : mag2;
                        qneg <= bus.sgn & (bus.opera1[W-1] ^ bus.opera2[2*W-1]);
                        rneg <= bus.sgn & bus.opera2[2*W-1];
                    end else begin
                        opa  <= mag2lo;
                        acc  <= {{W{1'b0}}, mag1};
                        qneg <= bus.sgn & (bus.opera1[W-1] ^ bus.opera2[W-1]);
                        rneg <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (mode_div) begin
                        rem <= ge ? diff[W-1:0] : trial[W-1:0];
                        acc <= {acc[2*W-2:0], ge};
                    end else begin
                        acc <= {msum, acc[W-1:1]};
                    end
                end
                FIX: begin
                    res_q <= dbz_pend ? acc : (mode_div ? {r_s, q_s[W-1:0]} : q_s);
                    dbz_q <= dbz_pend;
                    ovf_q <= mode_div & ~dbz_pend & ovf_c;
                end
                default: ;
            endcase
        end
    end

    // Output register stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.result <= '0;
            bus.valid  <= 1'b0;
            bus.busy   <= 1'b0;
            bus.dbz    <= 1'b0;
            bus.ovf    <= 1'b0;
        end else begin
            bus.result <= res_q;
            bus.valid  <= (state == DONE);
            bus.busy   <= (state == CALC) || (state == FIX);
            bus.dbz    <= dbz_q;
            bus.ovf    <= ovf_q;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vectors, a plain-arithmetic reference model,
// and a per-cycle compare of busy/valid/result/flags against it.
module tb_muldiv_seq;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    muldiv_seq_if #(.WIDTH(W)) bus ();
    muldiv_seq_if #(.WIDTH(8)) bus8 ();

    muldiv_seq #(.WIDTH(W)) dut  (.clock(clock), .reset(reset), .bus(bus));
    muldiv_seq #(.WIDTH(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8));

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // expectation of the current operation
    int          e0 = -1;
    int          lat = 0;
    bit          zero_mode = 1'b1;
    logic [63:0] exp_res;
    bit          exp_dbz, exp_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: ordinary 64-bit arithmetic; SV '/' truncates toward zero and
    // '%' takes the dividend's sign, matching the required semantics.
    function automatic logic [63:0] model(input bit div, input bit sg, input logic [31:0] a,
                                          input logic [63:0] b, output bit mdbz, output bit movf);
        longint sa, sb, sq, sr;
        logic [63:0] uq, ur;
        mdbz = 1'b0;
        movf = 1'b0;
        if (!div) begin
            if (sg) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b[31:0]));
                return sa * sb;
            end
            return {32'b0, a} * {32'b0, b[31:0]};
        end
        if (a == 32'd0) begin
            mdbz = 1'b1;
            return {b[31:0], 32'hFFFF_FFFF};
        end
        if (sg) begin
            sa = longint'($signed(a));
            sb = $signed(b);
            sq = sb / sa;
            sr = sb % sa;
            movf = (sq > 64'sd2147483647) || (sq < -64'sd2147483648);
            return {sr[31:0], sq[31:0]};
        end
        uq = b / {32'b0, a};
        ur = b % {32'b0, a};
        movf = (uq[63:32] != 32'd0);
        return {ur[31:0], uq[31:0]};
    endfunction

    task automatic compare();
        int k;
        if (zero_mode) begin
            chk("rst_result", bus.result, 64'd0);
            chk("rst_valid",  bus.valid,  64'd0);
            chk("rst_busy",   bus.busy,   64'd0);
            chk("rst_dbz",    bus.dbz,    64'd0);
            chk("rst_ovf",    bus.ovf,    64'd0);
        end else if (e0 >= 0) begin
            k = cyc - e0;
            if (k >= 1) begin
                chk("busy",  bus.busy,  64'(k < lat));
                chk("valid", bus.valid, 64'(k >= lat));
                if (k >= lat) begin
                    chk("result", bus.result, exp_res);
                    chk("dbz",    bus.dbz,    64'(exp_dbz));
                    chk("ovf",    bus.ovf,    64'(exp_ovf));
                end else begin
                    chk("dbz_busy", bus.dbz, 64'd0);
                    chk("ovf_busy", bus.ovf, 64'd0);
                end
            end
        end
    endtask

    task automatic launch(input bit div, input bit sg, input logic [31:0] a, input logic [63:0] b);
        bit md, mo;
        @(negedge clock); #1;
        bus.start  = 1'b1;
        bus.muordi = div;
        bus.sgn    = sg;
        bus.opera1 = a;
        bus.opera2 = b;
        exp_res    = model(div, sg, a, b, md, mo);
        exp_dbz    = md;
        exp_ovf    = mo;
        lat        = (div && a == 32'd0) ? 2 : (div ? 2 * W + 2 : W + 2);
        e0         = cyc + 1;
        zero_mode  = 1'b0;
        @(negedge clock); #1;
        // inputs change freely once accepted
        bus.start  = 1'b0;
        bus.muordi = 1'($urandom);
        bus.sgn    = 1'($urandom);
        bus.opera1 = $urandom;
        bus.opera2 = {$urandom, $urandom};
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic run(input bit div, input bit sg, input logic [31:0] a, input logic [63:0] b);
        launch(div, sg, a, b);
        wait_cyc(e0 + lat);
    endtask

    initial begin
        bit d, o;
        int e8;
        bus.start = 1'b0; bus.muordi = 1'b0; bus.sgn = 1'b0; bus.opera1 = '0; bus.opera2 = '0;
        bus8.start = 1'b0; bus8.muordi = 1'b0; bus8.sgn = 1'b0; bus8.opera1 = '0; bus8.opera2 = '0;

        fork
            forever begin
                @(negedge clock);
                compare();
            end
        join_none

        // pin the model to hand-computed values
        chk("model_mul_s",  model(1'b0, 1'b1, 32'hFFFFFFFD, 64'd7, d, o), 64'hFFFFFFFFFFFFFFEB);
        chk("model_mul_u",  model(1'b0, 1'b0, 32'hFFFFFFFD, 64'd7, d, o), 64'h00000006FFFFFFEB);
        chk("model_div_s",  model(1'b1, 1'b1, 32'd7, 64'hFFFFFFFFFFFFFF9C, d, o), 64'hFFFFFFFEFFFFFFF2);
        chk("model_div_u",  model(1'b1, 1'b0, 32'd7, 64'd100, d, o), 64'h000000020000000E);
        chk("model_ovf",    model(1'b1, 1'b0, 32'd1, 64'h0000000100000000, d, o), 64'd0);
        chk("model_ovf_f",  64'(o), 64'd1);
        chk("model_dbz",    model(1'b1, 1'b0, 32'd0, 64'h1212121212121212, d, o), 64'h12121212FFFFFFFF);
        chk("model_dbz_f",  64'(d), 64'd1);

        repeat (2) @(negedge clock);
        #1 reset = 1'b0;

        run(1'b0, 1'b1, 32'hFFFFFFFD, 64'd7);
        run(1'b0, 1'b0, 32'hFFFFFFFD, 64'd7);
        run(1'b1, 1'b1, 32'd7, 64'hFFFFFFFFFFFFFF9C);
        run(1'b1, 1'b0, 32'd7, 64'd100);
        run(1'b1, 1'b1, 32'd1, 64'hFFFFFFFF80000000);   // q = -2^31, fits
        run(1'b1, 1'b1, 32'd1, 64'h0000000080000000);   // q = 2^31, signed ovf
        run(1'b1, 1'b0, 32'd1, 64'h0000000100000000);   // unsigned ovf
        run(1'b1, 1'b1, 32'd1, 64'h0000000100000000);
        run(1'b1, 1'b0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        run(1'b1, 1'b1, 32'hFFFFFFFE, 64'd7);           // 7 / -2 = -3 r 1
        run(1'b1, 1'b1, 32'd7, 64'hFFFFFFFFFFFFFFF9);   // -7 / 7 = -1 r 0
        run(1'b0, 1'b1, 32'h80000000, 64'h80000000);
        run(1'b1, 1'b0, 32'd0, 64'h1212121212121212);   // divide by zero
        run(1'b1, 1'b1, 32'd0, 64'hFFFFFFFF87654321);
        run(1'b0, 1'b0, 32'd12345, 64'd0);

        // stray start during CALC is ignored
        launch(1'b0, 1'b1, 32'hFFFFFFFD, 64'd7);
        wait_cyc(e0 + 4);
        #1 bus.start = 1'b1;
        @(negedge clock); #1 bus.start = 1'b0;
        wait_cyc(e0 + lat);

        // mid-operation reset discards the divide
        launch(1'b1, 1'b1, 32'd7, 64'hFFFFFFFFFFFFFF9C);
        wait_cyc(e0 + 9);
        #1;
        reset     = 1'b1;
        e0        = -1;
        zero_mode = 1'b1;
        @(negedge clock); #1 reset = 1'b0;
        repeat (3) @(negedge clock);

        // fresh operation with normal latency after the abort
        run(1'b1, 1'b0, 32'd7, 64'd100);

        // WIDTH=8: -128 * -1 = 128
        @(negedge clock); #1;
        bus8.start  = 1'b1;
        bus8.muordi = 1'b0;
        bus8.sgn    = 1'b1;
        bus8.opera1 = 8'h80;
        bus8.opera2 = 16'h00FF;
        e8 = cyc + 1;
        @(negedge clock); #1 bus8.start = 1'b0;
        wait_cyc(e8 + 9);
        chk("w8_valid_early", bus8.valid, 64'd0);
        chk("w8_busy_early",  bus8.busy,  64'd1);
        wait_cyc(e8 + 10);
        chk("w8_valid",  bus8.valid,  64'd1);
        chk("w8_busy",   bus8.busy,   64'd0);
        chk("w8_result", bus8.result, 64'h0080);
        chk("w8_ovf",    bus8.ovf,    64'd0);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
